// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
// life_engine : Conway's Game of Life engine, one board row evaluated per cycle
// Rev 1.0
// ============================================================================
module life_engine #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int GEN_W = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_valid,
  input  logic [ROWS*COLS-1:0]              load_board,
  input  logic                              clear,
  input  logic                              step_req,
  input  logic                              run,
  input  logic                              wrap_en,
  output logic [ROWS*COLS-1:0]              board_o,
  output logic [GEN_W-1:0]                  generation_o,
  output logic [$clog2(ROWS*COLS+1)-1:0]    population_o,
  output logic                              busy,
  output logic                              gen_done,
  output logic                              stable_o
);

  localparam int CELLS = ROWS * COLS;
  localparam int POP_W = $clog2(CELLS + 1);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  logic [1:0]       state, state_next;
  logic [ROW_W-1:0] row_idx;
  logic [CELLS-1:0] shadow;
  logic [COLS-1:0]  row_next;
  logic             wrap_lat;
  logic             last_row;
  logic             do_clear, do_load, do_start, do_row, do_commit;
  logic [POP_W-1:0] pop;

  function automatic logic cell_at(input logic [CELLS-1:0] b, input int r,
                                   input int c, input logic wrap);
    int   rr, cc;
    logic v;
    v  = 1'b0;
    rr = r;
    cc = c;
    if (wrap) begin
      rr = (r + ROWS) % ROWS;
      cc = (c + COLS) % COLS;
      v  = b[rr*COLS + cc];
    end else if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
      v = b[rr*COLS + cc];
    end
    return v;
  endfunction

  function automatic logic [COLS-1:0] row_eval(input logic [CELLS-1:0] b,
                                               input int r, input logic wrap);
    logic [COLS-1:0] res;
    int              n;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      n = 0;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if (dr != 0 || dc != 0) n += int'(cell_at(b, r + dr, c + dc, wrap));
        end
      end
      res[c] = (n == 3) || (b[r*COLS + c] && n == 2);
    end
    return res;
  endfunction

  assign last_row = (row_idx == ROW_W'(ROWS - 1));
  assign row_next = row_eval(board_o, int'(row_idx), wrap_lat);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!clear && !load_valid && (step_req || run)) state_next = COMPUTE;
      COMPUTE: if (last_row) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only the highest-priority IDLE request produces a strobe.
  always_comb begin
    busy      = 1'b0;
    do_clear  = 1'b0;
    do_load   = 1'b0;
    do_start  = 1'b0;
    do_row    = 1'b0;
    do_commit = 1'b0;
    case (state)
      IDLE: begin
        do_clear = clear;
        do_load  = !clear && load_valid;
        do_start = !clear && !load_valid && (step_req || run);
      end
      COMPUTE: begin
        busy   = 1'b1;
        do_row = 1'b1;
      end
      COMMIT: begin
        busy      = 1'b1;
        do_commit = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      board_o      <= '0;
      generation_o <= '0;
      stable_o     <= 1'b0;
      gen_done     <= 1'b0;
      shadow       <= '0;
      row_idx      <= '0;
      wrap_lat     <= 1'b0;
    end else begin
      gen_done <= 1'b0;
      if (do_clear) begin
        board_o      <= '0;
        generation_o <= '0;
        stable_o     <= 1'b0;
      end
      if (do_load) begin
        board_o      <= load_board;
        generation_o <= '0;
        stable_o     <= 1'b0;
      end
      if (do_start) begin
        wrap_lat <= wrap_en;
        row_idx  <= '0;
      end
      if (do_row) begin
        shadow[int'(row_idx)*COLS +: COLS] <= row_next;
        row_idx <= last_row ? '0 : row_idx + ROW_W'(1);
      end
      if (do_commit) begin
        board_o  <= shadow;
        gen_done <= 1'b1;
        stable_o <= (shadow == board_o);
        if (generation_o != {GEN_W{1'b1}}) generation_o <= generation_o + GEN_W'(1);
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < CELLS; i++) pop = pop + POP_W'(board_o[i]);
  end
  assign population_o = pop;

endmodule
`default_nettype wire

// File: tb/tb_life_engine.sv
`default_nettype none
// ============================================================================
// tb_life_engine : directed + random checks of life_engine against a grid model
// Rev 1.0
// ============================================================================
module tb_life_engine;

  localparam int R  = 16;
  localparam int C  = 16;
  localparam int GW = 4;
  localparam int N  = R * C;
  localparam int PW = $clog2(N + 1);
  localparam int GMAX = (1 << GW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, load_valid, clear, step_req, run, wrap_en;
  logic [N-1:0]  load_board, board_o;
  logic [GW-1:0] generation_o;
  logic [PW-1:0] population_o;
  logic          busy, gen_done, stable_o;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] mb;
  int           mgen;
  bit           mstable;

  always #5 clk = ~clk;

  life_engine #(.ROWS(R), .COLS(C), .GEN_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_board(load_board),
    .clear(clear), .step_req(step_req), .run(run), .wrap_en(wrap_en),
    .board_o(board_o), .generation_o(generation_o), .population_o(population_o),
    .busy(busy), .gen_done(gen_done), .stable_o(stable_o)
  );

  // Whole-board reference generation on a 2-D grid
  function automatic logic [N-1:0] life_ref(input logic [N-1:0] b, input bit wrap);
    bit           g [R][C];
    logic [N-1:0] nb;
    int           n, rr, cc;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) g[r][c] = b[r*C + c];
    nb = '0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + R) % R;
              cc = (cc + C) % C;
            end else if (rr < 0 || rr >= R || cc < 0 || cc >= C) continue;
            n += int'(g[rr][cc]);
          end
        end
        nb[r*C + c] = (n == 3) || (g[r][c] && n == 2);
      end
    end
    return nb;
  endfunction

  function automatic logic [N-1:0] rand_board();
    logic [N-1:0] b;
    for (int i = 0; i < N / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_b({tag, "/board"}, board_o, mb);
    check({tag, "/gen"}, 32'(generation_o), 32'(mgen));
    check({tag, "/pop"}, 32'(population_o), 32'($countones(mb)));
    check({tag, "/stable"}, 32'(stable_o), 32'(mstable));
  endtask

  task automatic load_model(input logic [N-1:0] b);
    load_board = b;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    mb = b;
    mgen = 0;
    mstable = 1'b0;
  endtask

  // One step_req generation; with noise, clear/load/step are thrown at the busy engine
  task automatic do_step(input bit wrap, input bit noise);
    logic [N-1:0] nb;
    bit           early;
    nb = life_ref(mb, wrap);
    wrap_en  = wrap;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check("busy_start", 32'(busy), 32'd1);
    early = 1'b0;
    for (int k = 1; k <= R; k++) begin
      if (noise && k >= 2 && k <= 5) begin
        load_valid = 1'b1;
        clear      = 1'b1;
        step_req   = 1'b1;
        load_board = ~mb;
      end else begin
        load_valid = 1'b0;
        clear      = 1'b0;
        step_req   = 1'b0;
      end
      wrap_en = ~wrap;
      tick();
      if (gen_done) early = 1'b1;
    end
    check("no_early_done", 32'(early), 32'd0);
    check("busy_commit", 32'(busy), 32'd1);
    tick();
    mstable = (nb == mb);
    mb = nb;
    if (mgen < GMAX) mgen++;
    check("gen_done", 32'(gen_done), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    check_all("step");
    tick();
    check("done_pulse", 32'(gen_done), 32'd0);
    check("no_queue", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [N-1:0] b, e;
    logic [N-1:0] nb;
    bit           seen;
    int           cnt;

    rst_n = 1'b0; load_valid = 1'b0; clear = 1'b0; step_req = 1'b0;
    run = 1'b0; wrap_en = 1'b0; load_board = '0;
    tick();
    tick();
    mb = '0; mgen = 0; mstable = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(gen_done), 32'd0);
    check_all("reset");
    rst_n = 1'b1;

    // Vertical blinker, no wrap
    b = '0; b[6*C+7] = 1'b1; b[7*C+7] = 1'b1; b[8*C+7] = 1'b1;
    load_model(b);
    check_all("load_blinker");
    do_step(1'b0, 1'b0);
    e = '0; e[7*C+6] = 1'b1; e[7*C+7] = 1'b1; e[7*C+8] = 1'b1;
    check_b("blinker_h", board_o, e);
    check("blinker_pop", 32'(population_o), 32'd3);
    check("blinker_gen", 32'(generation_o), 32'd1);

    // clear beats load in IDLE
    clear = 1'b1; load_valid = 1'b1; load_board = rand_board();
    tick();
    clear = 1'b0; load_valid = 1'b0;
    mb = '0; mgen = 0; mstable = 1'b0;
    check_all("clear");

    // Row-0 triple straddling the column edge
    b = '0; b[15] = 1'b1; b[0] = 1'b1; b[1] = 1'b1;
    load_model(b);
    do_step(1'b1, 1'b0);
    e = '0; e[15*C] = 1'b1; e[0] = 1'b1; e[1*C] = 1'b1;
    check_b("wrap_on", board_o, e);
    load_model(b);
    do_step(1'b0, 1'b0);
    check_b("wrap_off", board_o, '0);
    check("wrap_off_pop", 32'(population_o), 32'd0);

    // Still-life block
    b = '0; b[4*C+4] = 1'b1; b[4*C+5] = 1'b1; b[5*C+4] = 1'b1; b[5*C+5] = 1'b1;
    load_model(b);
    do_step(1'b0, 1'b0);
    check("block_stable", 32'(stable_o), 32'd1);
    check_b("block_board", board_o, b);
    load_model(b);
    check("reload_stable", 32'(stable_o), 32'd0);
    check("reload_gen", 32'(generation_o), 32'd0);

    for (int i = 0; i < 4; i++) begin
      load_model(rand_board());
      do_step(1'(($urandom() >> 3) & 1), 1'b0);
    end

    // Requests while busy are dropped
    load_model(rand_board());
    do_step(1'b1, 1'b1);

    // Reset during the 5th COMPUTE cycle
    load_model(rand_board());
    wrap_en = 1'b0; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mb = '0; mgen = 0; mstable = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(gen_done), 32'd0);
    check_all("midrst");
    seen = 1'b0;
    for (int k = 0; k < R + 4; k++) begin
      tick();
      if (gen_done || busy) seen = 1'b1;
    end
    check("midrst_quiet", 32'(seen), 32'd0);

    // Free-running with saturation of the 4-bit generation counter
    load_model(rand_board());
    wrap_en = 1'b1; run = 1'b1;
    tick();
    for (int g = 1; g <= 20; g++) begin
      nb = life_ref(mb, 1'b1);
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (!gen_done && cnt < 4 * (R + 2));
      if (g == 20) run = 1'b0;
      mstable = (nb == mb);
      mb = nb;
      if (mgen < GMAX) mgen++;
      check("run_period", 32'(cnt), (g == 1) ? 32'(R + 1) : 32'(R + 2));
      check_all("run");
    end
    tick();
    check("run_stop", 32'(busy), 32'd0);
    check("run_sat", 32'(generation_o), 32'(GMAX));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
